// File: rtl/store_align_unit_pkg.sv
// Shared store/load definitions for the MEM stage: funct3 codes, size masks
// and the store-alignment FSM states.
`timescale 1ns/1ps
package store_align_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } st_state_e;

    // An all-zero mask marks an illegal store funct3.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3)
            F3_SB:   size_mask = MASK_B;
            F3_SH:   size_mask = MASK_H;
            F3_SW:   size_mask = MASK_W;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Store request / data-memory write bundle between the pipeline, the store
// aligner and data memory. The aligner sits on the slave side.
`timescale 1ns/1ps
interface store_align_unit_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [2:0]        select_store;
    logic              st_done;
    logic              st_err;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    modport master (
        output st_valid, st_addr, st_data, select_store, mem_gnt,
        input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  st_valid, st_addr, st_data, select_store, mem_gnt,
        output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_align_unit_lane_shift.sv
// Combinational lane steering: places the store bytes into an 8-lane window
// starting at the byte offset, so lanes 7:4 belong to the following word.
`timescale 1ns/1ps
module store_lane_shift
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    input  logic [2:0]  i_sel,
    output logic [7:0]  o_lanes8,
    output logic [63:0] o_data64,
    output logic        o_illegal,
    output logic        o_crosses
);
    logic [3:0] w_mask;

    always_comb begin
        w_mask    = size_mask(i_sel);
        o_illegal = (w_mask == 4'b0000);
        o_lanes8  = {4'b0000, w_mask} << i_off;
        o_data64  = {32'h0000_0000, i_data} << {i_off, 3'b000};
        o_crosses = |o_lanes8[7:4];
    end
endmodule

// File: rtl/store_align_unit.sv
// Store aligner: turns one pipeline store into one or two word-aligned
// data-memory write beats with byte enables, holding the pipeline meanwhile.
`timescale 1ns/1ps
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    store_align_unit_if.slave   bus
);
    st_state_e         r_state, w_state_nxt;
    logic              r_st_ready, w_st_ready_nxt;
    logic              r_st_done, w_st_done_nxt;
    logic              r_st_err, w_st_err_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]        r_mem_be, w_mem_be_nxt;
    logic [ADDR_W-1:0] r_b1_addr, w_b1_addr_nxt;
    logic [31:0]       r_b1_wdata, w_b1_wdata_nxt;
    logic [3:0]        r_b1_be, w_b1_be_nxt;
    logic              r_need2, w_need2_nxt;

    logic [7:0]        w_lanes8;
    logic [63:0]       w_data64;
    logic              w_illegal;
    logic              w_crosses;
    logic              w_accept;
    logic [ADDR_W-1:0] w_beat0_addr;

    store_lane_shift u_lane_shift (
        .i_off     (bus.st_addr[1:0]),
        .i_data    (bus.st_data),
        .i_sel     (bus.select_store),
        .o_lanes8  (w_lanes8),
        .o_data64  (w_data64),
        .o_illegal (w_illegal),
        .o_crosses (w_crosses)
    );

    assign w_accept     = bus.st_valid && r_st_ready && (r_state == ST_IDLE);
    assign w_beat0_addr = {bus.st_addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_st_ready  <= 1'b0;
            r_st_done   <= 1'b0;
            r_st_err    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_b1_addr   <= '0;
            r_b1_wdata  <= '0;
            r_b1_be     <= '0;
            r_need2     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_st_ready  <= w_st_ready_nxt;
            r_st_done   <= w_st_done_nxt;
            r_st_err    <= w_st_err_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_b1_addr   <= w_b1_addr_nxt;
            r_b1_wdata  <= w_b1_wdata_nxt;
            r_b1_be     <= w_b1_be_nxt;
            r_need2     <= w_need2_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_st_ready_nxt  = 1'b0;
        w_st_done_nxt   = 1'b0;
        w_st_err_nxt    = 1'b0;
        w_mem_req_nxt   = r_mem_req;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_b1_addr_nxt   = r_b1_addr;
        w_b1_wdata_nxt  = r_b1_wdata;
        w_b1_be_nxt     = r_b1_be;
        w_need2_nxt     = r_need2;

        case (r_state)
            ST_IDLE: begin
                w_st_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_st_ready_nxt = 1'b0;
                    // Dropped stores never raise mem_req, so memory stays untouched.
                    if (w_illegal || (w_crosses && !ALLOW_MISALIGNED)) begin
                        w_state_nxt   = ST_DONE;
                        w_st_done_nxt = 1'b1;
                        w_st_err_nxt  = 1'b1;
                    end else begin
                        w_state_nxt     = ST_BEAT0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_addr_nxt  = w_beat0_addr;
                        w_mem_wdata_nxt = w_data64[31:0];
                        w_mem_be_nxt    = w_lanes8[3:0];
                        w_b1_addr_nxt   = w_beat0_addr + ADDR_W'(4);
                        w_b1_wdata_nxt  = w_data64[63:32];
                        w_b1_be_nxt     = w_lanes8[7:4];
                        w_need2_nxt     = w_crosses;
                    end
                end
            end
            ST_BEAT0: begin
                if (bus.mem_gnt) begin
                    if (r_need2) begin
                        w_state_nxt     = ST_BEAT1;
                        w_mem_addr_nxt  = r_b1_addr;
                        w_mem_wdata_nxt = r_b1_wdata;
                        w_mem_be_nxt    = r_b1_be;
                    end else begin
                        w_state_nxt     = ST_DONE;
                        w_st_done_nxt   = 1'b1;
                        w_mem_req_nxt   = 1'b0;
                        w_mem_addr_nxt  = '0;
                        w_mem_wdata_nxt = '0;
                        w_mem_be_nxt    = '0;
                    end
                end
            end
            ST_BEAT1: begin
                if (bus.mem_gnt) begin
                    w_state_nxt     = ST_DONE;
                    w_st_done_nxt   = 1'b1;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_wdata_nxt = '0;
                    w_mem_be_nxt    = '0;
                end
            end
            ST_DONE: begin
                w_state_nxt    = ST_IDLE;
                w_st_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.st_ready  = r_st_ready;
    assign bus.st_done   = r_st_done;
    assign bus.st_err    = r_st_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
endmodule
